// File: rtl/pla_opa_line_encoder.sv
// Purpose: re-encode a captured opa PLA line vector into a stream of set-line indices, lowest first.
// Latency: first beat in the cycle after accept; one beat per cycle, one idle cycle between vectors.
// Backpressure: out_* held stable while out_valid && !out_ready; in_ready only in IDLE.
module pla_opa_line_encoder #(
    parameter int WIDTH         = 69,
    parameter int IDX_W         = 7,
    parameter int RESERVED_BASE = 61
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [IDX_W-1:0] out_seq,
    output logic [IDX_W-1:0] out_count,
    output logic             out_last,
    output logic             out_empty,
    output logic             err_reserved
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT  = 2'd1,
        EMPTY = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] pending;
    logic [IDX_W-1:0] seq_q;
    logic [IDX_W-1:0] count_q;
    logic [IDX_W-1:0] vec_count;
    logic [IDX_W-1:0] low_idx;
    logic             single_bit;
    logic             accept;
    logic             emit_beat;

    always_comb begin
        vec_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            vec_count = vec_count + IDX_W'(in_vec[i]);
        end
    end

    // Scan downward so the lowest set bit wins.
    always_comb begin
        low_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    assign single_bit = (pending != '0) && ((pending & (pending - WIDTH'(1))) == '0);
    assign accept     = in_valid && in_ready;
    assign emit_beat  = (state == EMIT) && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_idx   = '0;
        out_seq   = '0;
        out_count = '0;
        out_last  = 1'b0;
        out_empty = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) begin
                    state_nxt = (in_vec == '0) ? EMPTY : EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                out_idx   = low_idx;
                out_seq   = seq_q;
                out_count = count_q;
                out_last  = single_bit;
                if (out_ready && single_bit) begin
                    state_nxt = IDLE;
                end
            end
            EMPTY: begin
                out_valid = 1'b1;
                out_empty = 1'b1;
                out_last  = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Clearing the lowest set bit via pending & (pending - 1) matches the priority encoder.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending      <= '0;
            seq_q        <= '0;
            count_q      <= '0;
            err_reserved <= 1'b0;
        end else if (accept) begin
            pending      <= in_vec;
            count_q      <= vec_count;
            seq_q        <= '0;
            err_reserved <= err_reserved | (|in_vec[WIDTH-1:RESERVED_BASE]);
        end else if (emit_beat) begin
            pending <= pending & (pending - WIDTH'(1));
            seq_q   <= seq_q + IDX_W'(1);
        end
    end

endmodule

// File: tb/tb_pla_opa_line_encoder.sv
// Scoreboard bench for pla_opa_line_encoder: directed cases then randomized vectors and backpressure.
module tb_pla_opa_line_encoder;

    localparam int W = 69;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_vec = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [6:0]   out_idx;
    logic [6:0]   out_seq;
    logic [6:0]   out_count;
    logic         out_last;
    logic         out_empty;
    logic         err_reserved;

    typedef struct packed {
        logic [6:0] idx;
        logic [6:0] seq;
        logic [6:0] cnt;
        logic       last;
        logic       empty;
    } beat_t;

    beat_t exp_q[$];
    int    checks   = 0;
    int    passes   = 0;
    int    cyc      = 0;
    int    rdy_mode = 0;

    always #5 clk = ~clk;

    pla_opa_line_encoder dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_vec       (in_vec),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_idx      (out_idx),
        .out_seq      (out_seq),
        .out_count    (out_count),
        .out_last     (out_last),
        .out_empty    (out_empty),
        .err_reserved (err_reserved)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // out_ready: 0 = always ready, 1 = random, otherwise stalled
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor / scoreboard
    initial begin
        beat_t        b;
        beat_t        cur;
        beat_t        prev_dat;
        logic         prev_hold;
        logic         prev_rst;
        logic         err_model;
        int           n;
        int           k;
        prev_hold = 1'b0;
        prev_rst  = 1'b1;
        err_model = 1'b0;
        prev_dat  = '0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            cur = '{idx: out_idx, seq: out_seq, cnt: out_count, last: out_last, empty: out_empty};
            if (prev_rst) begin
                check("reset_outputs", 32'(cur), 32'd0);
            end
            check("in_ready", 32'(in_ready), 32'(exp_q.size() == 0 && !rst));
            check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            check("err_reserved", 32'(err_reserved), 32'(err_model));
            if (prev_hold) begin
                check("hold_stable", 32'({out_valid, cur}), 32'({1'b1, prev_dat}));
            end
            if (!rst && out_valid && out_ready && exp_q.size() != 0) begin
                b = exp_q.pop_front();
                check("beat", 32'(cur), 32'(b));
            end
            if (rst) begin
                exp_q.delete();
                err_model = 1'b0;
            end else if (in_valid && in_ready) begin
                n = 0;
                for (int i = 0; i < W; i++) if (in_vec[i]) n++;
                if (n == 0) begin
                    exp_q.push_back('{idx: 7'd0, seq: 7'd0, cnt: 7'd0, last: 1'b1, empty: 1'b1});
                end else begin
                    k = 0;
                    for (int i = 0; i < W; i++) begin
                        if (in_vec[i]) begin
                            exp_q.push_back('{idx: 7'(i), seq: 7'(k), cnt: 7'(n),
                                              last: (k == n - 1), empty: 1'b0});
                            k++;
                        end
                    end
                end
                err_model = err_model | (|in_vec[W-1:61]);
            end
            prev_hold = out_valid && !out_ready && !rst;
            prev_dat  = cur;
            prev_rst  = rst;
        end
    end

    task automatic send(input logic [W-1:0] v, output int acc_cyc);
        bit          got;
        logic [95:0] junk;
        got     = 1'b0;
        acc_cyc = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_vec   = v;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk);
            if (in_ready) begin
                got     = 1'b1;
                acc_cyc = cyc;
            end
        end
        check("accept_in_time", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        junk     = {$urandom(), $urandom(), $urandom()};
        in_vec   = junk[W-1:0];
    endtask

    task automatic wait_idle();
        bit got;
        got = 1'b0;
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) got = 1'b1;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    function automatic logic [W-1:0] bits4(input int a, input int b, input int c, input int d);
        logic [W-1:0] v;
        v = '0;
        if (a >= 0) v[a] = 1'b1;
        if (b >= 0) v[b] = 1'b1;
        if (c >= 0) v[c] = 1'b1;
        if (d >= 0) v[d] = 1'b1;
        return v;
    endfunction

    initial begin
        int           a1;
        int           a2;
        int           dens;
        logic [W-1:0] v;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        rdy_mode = 0;

        send(bits4(11, -1, -1, -1), a1);
        wait_idle();
        send(bits4(0, 3, 25, 60), a1);
        wait_idle();

        rdy_mode = 2;
        send(bits4(1, 2, -1, -1), a1);
        repeat (3) @(negedge clk);
        rdy_mode = 0;
        wait_idle();

        send('0, a1);
        send(bits4(64, -1, -1, -1), a1);
        send(bits4(7, -1, -1, -1), a1);
        wait_idle();

        v = '1;
        send(v, a1);
        send(bits4(30, -1, -1, -1), a2);
        check("full_vector_spacing", 32'(a2 - a1), 32'd70);
        wait_idle();

        send(bits4(5, 9, 40, -1), a1);
        @(negedge clk);
        rdy_mode = 2;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        rdy_mode = 1;

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(4))
                0:       dens = 0;
                1:       dens = 3;
                2:       dens = 15;
                3:       dens = 50;
                default: dens = 100;
            endcase
            for (int i = 0; i < W; i++) v[i] = ($urandom_range(99) < dens);
            send(v, a1);
            repeat ($urandom_range(2)) @(posedge clk);
        end
        wait_idle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
